// File: rtl/pong_frame_scanner_if.sv
// Position inputs and row-scan outputs of pong_frame_scanner.
// PONG_BALL_BLINK_EN adds the ball_blink input.
interface pong_frame_scanner_if #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned POS_BITS = 4,
  parameter int unsigned ROW_BITS = 4
);
  logic                enable;
  logic [POS_BITS-1:0] player_top;
  logic [POS_BITS-1:0] player_down;
  logic [POS_BITS-1:0] player_left;
  logic [POS_BITS-1:0] player_right;
  logic [3:0]          player_en;
  logic [POS_BITS-1:0] ball_x;
  logic [POS_BITS-1:0] ball_y;
  logic                ball_visible;
`ifdef PONG_BALL_BLINK_EN
  logic                ball_blink;
`else
`endif
  logic [WIDTH-1:0]    row_data;
  logic [ROW_BITS-1:0] row_index;
  logic                row_valid;
  logic                frame_start;
  logic [7:0]          frame_cnt;

  modport master (
    output enable, player_top, player_down, player_left, player_right,
    output player_en, ball_x, ball_y, ball_visible,
`ifdef PONG_BALL_BLINK_EN
    output ball_blink,
`else
`endif
    input  row_data, row_index, row_valid, frame_start, frame_cnt
  );

  modport slave (
    input  enable, player_top, player_down, player_left, player_right,
    input  player_en, ball_x, ball_y, ball_visible,
`ifdef PONG_BALL_BLINK_EN
    input  ball_blink,
`else
`endif
    output row_data, row_index, row_valid, frame_start, frame_cnt
  );
endinterface

// File: rtl/pong_frame_scanner.sv
// Row-scanning pong matrix renderer with per-frame position snapshot.
// PONG_BALL_BLINK_EN: ball_blink input makes the ball blink on odd frames.
module pong_frame_scanner #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned HEIGHT       = 16,
  parameter int unsigned PAD_SIZE     = 4,
  parameter int unsigned POS_BITS     = 4,
  parameter int unsigned ROW_BITS     = 4,
  parameter int unsigned ROW_HOLD     = 1024,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pong_frame_scanner_if.slave  bus
);

  localparam int unsigned PW      = POS_BITS + 2;
  localparam int unsigned CNT_MAX = (ROW_HOLD > BLANK_CYCLES) ? ROW_HOLD : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, LATCH, SCAN, BLANK} state_t;

  typedef struct packed {
    logic [POS_BITS-1:0] top;
    logic [POS_BITS-1:0] down;
    logic [POS_BITS-1:0] left;
    logic [POS_BITS-1:0] right;
    logic [3:0]          en;
    logic [POS_BITS-1:0] bx;
    logic [POS_BITS-1:0] by;
    logic                vis;
    logic                blink;
  } snap_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  snap_t               shadow_q;
  logic [WIDTH-1:0]    row_data_q;
  logic [ROW_BITS-1:0] row_index_q;
  logic                row_valid_q;
  logic                frame_start_q;
  logic [7:0]          frame_cnt_q;

  snap_t               live_c;
  snap_t               snap_c;
  logic [ROW_BITS-1:0] row_sel_c;
  int unsigned         rr_c;
  logic                ball_on_c;
  logic [WIDTH-1:0]    pix_c;

  // Paddle end is widened so start+size never wraps back into the matrix.
  function automatic logic paddle_hit(input logic en, input logic [POS_BITS-1:0] pos,
                                      input int unsigned idx);
    logic [PW-1:0] pad_end;
    pad_end = PW'(pos) + PW'(PAD_SIZE) - PW'(1);
    return !en || ((32'(pos) <= idx) && (idx <= 32'(pad_end)));
  endfunction

  function automatic logic pixel(input int unsigned r, input int unsigned c,
                                 input snap_t s, input logic ball_on);
    logic on;
    on = 1'b0;
    if (r == 0 || r == HEIGHT - 1) begin
      if (c == 0 || c == WIDTH - 1)
        on = 1'b1;
      else if (r == 0)
        on = paddle_hit(s.en[3], s.top, c);
      else
        on = paddle_hit(s.en[2], s.down, c);
    end else if (c == 0) begin
      on = paddle_hit(s.en[1], s.left, r);
    end else if (c == WIDTH - 1) begin
      on = paddle_hit(s.en[0], s.right, r);
    end
    if (ball_on && c >= 1 && c <= WIDTH - 2 && r == 32'(s.by) && c == 32'(s.bx))
      on = 1'b1;
    return on;
  endfunction

  always_comb begin
    live_c       = '0;
    live_c.top   = bus.player_top;
    live_c.down  = bus.player_down;
    live_c.left  = bus.player_left;
    live_c.right = bus.player_right;
    live_c.en    = bus.player_en;
    live_c.bx    = bus.ball_x;
    live_c.by    = bus.ball_y;
    live_c.vis   = bus.ball_visible;
`ifdef PONG_BALL_BLINK_EN
    live_c.blink = bus.ball_blink;
`else
    live_c.blink = 1'b0;
`endif
  end

  // Row 0 is rendered on the LATCH edge, so it must see the values being captured.
  assign snap_c    = (state == LATCH) ? live_c : shadow_q;
  assign row_sel_c = (state == LATCH) ? '0 : row_index_q + ROW_BITS'(1);
  assign rr_c      = 32'(row_sel_c);
  assign ball_on_c = snap_c.vis && !(snap_c.blink && frame_cnt_q[0]);

  for (genvar gc = 0; gc < WIDTH; gc++) begin : g_col
    assign pix_c[gc] = pixel(rr_c, gc, snap_c, ball_on_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      shadow_q      <= '0;
      row_data_q    <= '0;
      row_index_q   <= '0;
      row_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      frame_start_q <= 1'b0;
      case (state)
        IDLE: begin
          row_data_q  <= '0;
          row_index_q <= '0;
          row_valid_q <= 1'b0;
          cnt         <= '0;
          if (bus.enable) state <= LATCH;
        end
        LATCH: begin
          shadow_q      <= live_c;
          row_index_q   <= '0;
          row_data_q    <= pix_c;
          row_valid_q   <= 1'b1;
          frame_start_q <= 1'b1;
          cnt           <= '0;
          state         <= SCAN;
        end
        SCAN: begin
          if (cnt == CNT_W'(ROW_HOLD - 1)) begin
            cnt         <= '0;
            row_valid_q <= 1'b0;
            row_data_q  <= '0;
            state       <= BLANK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        BLANK: begin
          if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            cnt <= '0;
            if (row_index_q == ROW_BITS'(HEIGHT - 1)) begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
              row_index_q <= '0;
              state       <= bus.enable ? LATCH : IDLE;
            end else begin
              row_index_q <= row_index_q + ROW_BITS'(1);
              row_data_q  <= pix_c;
              row_valid_q <= 1'b1;
              state       <= SCAN;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.row_data    = row_data_q;
  assign bus.row_index   = row_index_q;
  assign bus.row_valid   = row_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: doc/pong_frame_scanner.md
Name: pong_frame_scanner

Overview:
- Registered, parametrised successor to the combinational row renderer for the pong LED matrix.
- Owns its own row-scan sequencing and snapshots all game positions once per frame, so a frame never tears.
- Generates per-row pixel data for a WIDTH x HEIGHT matrix with four paddles, walls, corners and the ball.
- Sits between the game logic (positions) and the matrix row driver.

Parameters:
- WIDTH, 16, matrix columns (>=4).
- HEIGHT, 16, matrix rows (>=4).
- PAD_SIZE, 4, paddle length in pixels.
- POS_BITS, 4, width of each position input.
- ROW_BITS, 4, width of row_index (>= clog2(HEIGHT)).
- ROW_HOLD, 1024, cycles each row is displayed (>=1).
- BLANK_CYCLES, 8, blanking cycles between rows (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  run scanning.
- player_top  in  POS_BITS  top paddle start column.
- player_down  in  POS_BITS  bottom paddle start column.
- player_left  in  POS_BITS  left paddle start row.
- player_right  in  POS_BITS  right paddle start row.
- player_en  in  4  presence per side {top,down,left,right} = bits [3:0].
- ball_x  in  POS_BITS  ball column.
- ball_y  in  POS_BITS  ball row.
- ball_visible  in  1  draw ball.
- row_data  out  WIDTH  pixels of current row; bit c = column c.
- row_index  out  ROW_BITS  row currently driven.
- row_valid  out  1  row_data is displayable.
- frame_start  out  1  one-cycle pulse on the first cycle of row 0.
- frame_cnt  out  8  completed frames, wraps 255 -> 0.

Behaviour:
- Reset: all outputs 0; state IDLE; shadow registers 0.
- States:
  - IDLE: outputs held at 0 (frame_cnt retains its value). Moves to LATCH when enable=1.
  - LATCH: one cycle; copies all position/enable/ball inputs into shadow registers. Next state SCAN with row_index=0.
  - SCAN: row_valid=1 for exactly ROW_HOLD cycles, then BLANK.
  - BLANK: row_valid=0 and row_data=0 for BLANK_CYCLES cycles.
    - If the row just shown was not HEIGHT-1: row_index increments and the FSM returns to SCAN.
    - If it was HEIGHT-1: frame_cnt increments; the FSM goes to LATCH if enable=1, else IDLE with row_index=0.
- row_data, row_index and row_valid are registered and change on the same edge. Pixel data is computed from the shadow registers only.
- frame_start = 1 on the first SCAN cycle of row 0.
- enable deasserted mid-frame: the current frame completes; the block stops at the frame boundary. rst mid-frame: immediate return to the reset state.
- Pixel rules (r = row, c = column). Interior range is [1, WIDTH-2] for columns and [1, HEIGHT-2] for rows.
  - Corners (0,0), (0,W-1), (H-1,0), (H-1,W-1) are always lit.
  - Top edge, r=0, interior c:
    - if player_en[3]: lit iff player_top <= c <= player_top+PAD_SIZE-1;
    - else solid wall (all lit).
  - Bottom edge, r=H-1: same rule with player_down and player_en[2].
  - Left edge, c=0, interior r: same rule with player_left and player_en[1].
  - Right edge, c=W-1, interior r: same rule with player_right and player_en[0].
  - Ball: lit iff ball_visible, r==ball_y, and 1 <= ball_x <= WIDTH-2. Out-of-range ball is not drawn. The ball is OR-ed with edge pixels only in the interior columns.
- Arithmetic: paddle end is computed at POS_BITS+2 width, so there is no wrap. Paddle pixels beyond the interior are clipped, never wrapped.

Optional Feature:
- Macro PONG_BALL_BLINK_EN.
- Defined: adds input port ball_blink (1 bit), snapshotted in LATCH. When the snapshot is 1, the ball is drawn only in frames where frame_cnt[0]==0.
- Undefined: no ball_blink port; the ball is drawn every frame per ball_visible.

Test Plan (ROW_HOLD=4, BLANK_CYCLES=1, defaults otherwise):
- Reset/start:
  - Stimulus: rst for 2 cycles, then enable=1.
  - Required: all outputs 0 during reset. LATCH takes 1 cycle. frame_start pulses together with row_index=0 and row_valid=1.
- Frame timing:
  - Stimulus: run one frame.
  - Required: each row valid 4 cycles, 1 blank cycle with row_data=0. 16 rows, then frame_cnt=1. The next frame_start comes 80 cycles plus 1 LATCH cycle after the first.
- Paddles and corners:
  - Stimulus: player_top=3, player_left=2, player_en=4'b1111.
  - Required: row 0 = 16'b1000_0000_0111_1001. Rows 2..5 have bit0=1; rows 1 and 6 have bit0=0.
- Clipping and walls:
  - Stimulus: player_down=14; player_en[0]=0.
  - Required: row 15 lights bits 14, 15 and 0 only. Column 15 is lit in every row.
- Ball:
  - Stimulus: ball (5,7), visible.
  - Required: row 7 bit5 set.
  - Stimulus: ball_x=15.
  - Required: no ball pixel drawn.
- Snapshot and stop:
  - Stimulus: change player_left mid-frame.
  - Required: row_data changes only after the next LATCH.
  - Stimulus: drop enable mid-frame.
  - Required: the frame completes, then the block enters IDLE.
